// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential radix-2 shift-add multiplier.
// Each multiply takes WIDTH cycles in BUSY and one cycle in DONE. Signed
// operands are multiplied as magnitudes, and the sign is applied when the
// result is loaded.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a multiply (accepted only in IDLE)
//   is_signed  1: two's-complement operands, 0: unsigned operands
//   A, B       multiplicand / multiplier (WIDTH bits)
//   busy       high in BUSY and DONE
//   done       one-cycle pulse while in DONE
//   result     registered 2*WIDTH-bit product
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accept edge
// BUSY  | one shift-add step per cycle, counter runs WIDTH -> 0
// DONE  | result valid, done pulses, returns to IDLE unconditionally
//
// WIDTH must be in 4..64 and 2^CNT_W must exceed WIDTH.

module shift_add_mul #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 neg;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_step;
   logic                 last_step;

   // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
   always_comb begin
      a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
      b_mag = (is_signed && B[WIDTH-1]) ? -B : B;
   end

   // sum holds the carry of the add; shifting {carry, acc} right by one
   // lands that carry in the accumulator MSB, so nothing is lost.
   always_comb begin
      sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      acc_step  = {sum, acc[WIDTH-1:1]};
      last_step = (cnt == CNT_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= CNT_W'(WIDTH);
               end
            end
            BUSY: begin
               acc    <= acc_step;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_W'(1);
               // Load on the same edge that enters DONE, from the final step.
               if (last_step) result <= neg ? -acc_step : acc_step;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul: three instances (WIDTH 32, 8, 16) sharing one
// clock and reset. Directed table, random single ops, multi-cycle corner
// sequences, and a back-to-back run with start held high.

module tb_shift_add_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic         start32, s32, busy32, done32;
   logic [31:0]  a32, b32;
   logic [63:0]  res32;
   logic         start8, s8, busy8, done8;
   logic [7:0]   a8, b8;
   logic [15:0]  res8;
   logic         start16, s16, busy16, done16;
   logic [15:0]  a16, b16;
   logic [31:0]  res16;

   shift_add_mul #(.WIDTH(32), .CNT_W(6)) u32 (
      .clk(clk), .rst(rst), .start(start32), .is_signed(s32), .A(a32), .B(b32),
      .busy(busy32), .done(done32), .result(res32));
   shift_add_mul #(.WIDTH(8), .CNT_W(4)) u8 (
      .clk(clk), .rst(rst), .start(start8), .is_signed(s8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .result(res8));
   shift_add_mul #(.WIDTH(16), .CNT_W(5)) u16 (
      .clk(clk), .rst(rst), .start(start16), .is_signed(s16), .A(a16), .B(b16),
      .busy(busy16), .done(done16), .result(res16));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: true integer product of the operands as the mode reads them,
   // reduced modulo 2^(2w).
   function automatic logic [127:0] model(input int w, input logic s,
                                          input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, p;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      sa = {64'd0, a & mask};
      sb = {64'd0, b & mask};
      if (s && a[w-1]) sa = sa - (128'sd1 <<< w);
      if (s && b[w-1]) sb = sb - (128'sd1 <<< w);
      p = sa * sb;
      return p & ((128'd1 << (2*w)) - 128'd1);
   endfunction

   task automatic drive(input int w, input logic st, input logic s,
                        input logic [63:0] a, input logic [63:0] b);
      case (w)
         32: begin start32 = st; s32 = s; a32 = a[31:0]; b32 = b[31:0]; end
         8:  begin start8  = st; s8  = s; a8  = a[7:0];  b8  = b[7:0];  end
         default: begin start16 = st; s16 = s; a16 = a[15:0]; b16 = b[15:0]; end
      endcase
   endtask

   function automatic logic get_done(input int w);
      case (w)
         32: return done32;
         8:  return done8;
         default: return done16;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         32: return busy32;
         8:  return busy8;
         default: return busy16;
      endcase
   endfunction

   function automatic logic [127:0] get_res(input int w);
      case (w)
         32: return 128'(res32);
         8:  return 128'(res8);
         default: return 128'(res16);
      endcase
   endfunction

   // Called at a negedge with the DUT idle. Returns the result seen in DONE,
   // edges from accept to done, cycles with busy high, and whether result
   // held still before done. Operands are scrambled right after accept.
   task automatic run_op(input int w, input logic s, input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] res, output int lat, output int bcnt,
                         output logic held);
      logic [127:0] prev;
      drive(w, 1'b1, s, a, b);
      @(posedge clk);
      @(negedge clk);
      drive(w, 1'b0, ~s, {$urandom, $urandom}, {$urandom, $urandom});
      prev = get_res(w);
      held = 1'b1;
      lat  = 0;
      bcnt = 0;
      while (!get_done(w) && lat < 200) begin
         if (get_busy(w)) bcnt++;
         if (get_res(w) !== prev) held = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (get_busy(w)) bcnt++;
      res = get_res(w);
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      int           w;
      logic         s;
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl[$];
   logic [32:0] hist [0:20000];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] res;
      int lat, bcnt, k, n, last, ops, idx;
      logic held, seen, s;
      logic [63:0] a, b;

      tbl.push_back('{32, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001});
      tbl.push_back('{32, 1'b1, 64'hFFFFFFFD, 64'h7,        128'hFFFFFFFFFFFFFFEB});
      tbl.push_back('{32, 1'b0, 64'h0,        64'h12345678, 128'h0});
      tbl.push_back('{32, 1'b1, 64'h0,        64'hFFFFFFFF, 128'h0});
      tbl.push_back('{32, 1'b1, 64'h80000000, 64'h80000000, 128'h4000000000000000});
      tbl.push_back('{32, 1'b1, 64'h80000000, 64'h1,        128'hFFFFFFFF80000000});
      tbl.push_back('{32, 1'b0, 64'h80000000, 64'h80000000, 128'h4000000000000000});
      tbl.push_back('{32, 1'b1, 64'h7FFFFFFF, 64'h80000000, 128'hC000000080000000});
      tbl.push_back('{32, 1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'h1});
      tbl.push_back('{32, 1'b0, 64'h6,        64'h7,        128'd42});
      tbl.push_back('{8,  1'b1, 64'h80, 64'h80, 128'h4000});
      tbl.push_back('{8,  1'b0, 64'h80, 64'h80, 128'h4000});
      tbl.push_back('{8,  1'b1, 64'h80, 64'h7F, 128'hC080});
      tbl.push_back('{8,  1'b0, 64'hFF, 64'hFF, 128'hFE01});
      tbl.push_back('{8,  1'b1, 64'hFF, 64'hFF, 128'h1});
      tbl.push_back('{8,  1'b1, 64'h7F, 64'h7F, 128'h3F01});
      tbl.push_back('{8,  1'b1, 64'h05, 64'hFD, 128'hFFF1});

      rst = 1'b1;
      drive(32, 1'b0, 1'b0, 64'h0, 64'h0);
      drive(8,  1'b0, 1'b0, 64'h0, 64'h0);
      drive(16, 1'b0, 1'b0, 64'h0, 64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy32", 128'(busy32), 128'd0);
      chk("reset_done32", 128'(done32), 128'd0);
      chk("reset_res32",  128'(res32),  128'd0);
      chk("reset_busy8",  128'(busy8),  128'd0);
      chk("reset_res8",   128'(res8),   128'd0);
      chk("reset_busy16", 128'(busy16), 128'd0);
      chk("reset_res16",  128'(res16),  128'd0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].b, res, lat, bcnt, held);
         chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].w));
         chk($sformatf("vec%0d_busy_cycles", i), 128'(bcnt), 128'(tbl[i].w + 1));
         chk($sformatf("vec%0d_result_held", i), 128'(held), 128'd1);
      end

      for (int i = 0; i < 20; i++) begin
         s = 1'($urandom_range(0, 1));
         a = 64'($urandom);
         b = 64'($urandom);
         run_op(32, s, a, b, res, lat, bcnt, held);
         chk($sformatf("rand32_%0d", i), res, model(32, s, a, b));
      end

      // A second start five edges into an operation must be ignored.
      drive(32, 1'b1, 1'b0, 64'd6, 64'd7);
      @(posedge clk);
      @(negedge clk);
      drive(32, 1'b0, 1'b0, 64'd6, 64'd7);
      k = 0;
      repeat (4) begin @(posedge clk); k++; @(negedge clk); end
      drive(32, 1'b1, 1'b1, 64'hFFFF, 64'h3);
      @(posedge clk); k++;
      @(negedge clk);
      drive(32, 1'b0, 1'b1, 64'hFFFF, 64'h3);
      while (!done32 && k < 200) begin @(posedge clk); k++; @(negedge clk); end
      chk("ignore_start_latency", 128'(k), 128'd32);
      chk("ignore_start_result", 128'(res32), 128'd42);
      @(posedge clk);
      @(negedge clk);
      chk("ignore_start_idle_after", 128'(busy32), 128'd0);

      // Reset ten edges into BUSY aborts without a done pulse.
      drive(32, 1'b1, 1'b0, 64'd6, 64'd7);
      @(posedge clk);
      @(negedge clk);
      drive(32, 1'b0, 1'b0, 64'd6, 64'd7);
      repeat (9) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 128'(busy32), 128'd0);
      chk("abort_done", 128'(done32), 128'd0);
      chk("abort_result", 128'(res32), 128'd0);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); @(negedge clk); if (done32) seen = 1'b1; end
      chk("abort_no_done", 128'(seen), 128'd0);
      run_op(32, 1'b0, 64'd6, 64'd7, res, lat, bcnt, held);
      chk("after_abort_result", res, 128'd42);
      chk("after_abort_latency", 128'(lat), 128'd32);

      // Reset wins over a simultaneous start.
      rst = 1'b1;
      drive(32, 1'b1, 1'b0, 64'd3, 64'd3);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(32, 1'b0, 1'b0, 64'd3, 64'd3);
      chk("rst_priority_busy", 128'(busy32), 128'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_priority_busy_later", 128'(busy32), 128'd0);

      // Start held high on the 16-bit instance: hist[n] holds the operands
      // present before edge n; a done after edge n belongs to edge n-16.
      n = 0; last = -1; ops = 0;
      while (ops < 1000 && n < 20000) begin
         s = 1'($urandom_range(0, 1));
         a = 64'($urandom_range(0, 65535));
         b = 64'($urandom_range(0, 65535));
         drive(16, 1'b1, s, a, b);
         hist[n + 1] = {s, a[15:0], b[15:0]};
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done16) begin
            idx = n - 16;
            if (idx >= 1) begin
               chk($sformatf("b2b_%0d_result", ops), 128'(res16),
                   model(16, hist[idx][32], 64'(hist[idx][31:16]), 64'(hist[idx][15:0])));
            end else begin
               chk($sformatf("b2b_%0d_early_done", ops), 128'(idx), 128'd1);
            end
            if (last >= 0) chk($sformatf("b2b_%0d_spacing", ops), 128'(n - last), 128'd18);
            last = n;
            ops++;
         end
      end
      chk("b2b_op_count", 128'(ops), 128'd1000);
      drive(16, 1'b0, 1'b0, 64'h0, 64'h0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("b2b_idle_after", 128'(busy16), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; legal range 4..64.
REQ-002 SHALL have parameter CNT_W, default 6: counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-006 SHALL have port is_signed, input, 1 bit: 1 means two's-complement operands; 0 means unsigned operands.
REQ-007 SHALL have port A, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port B, input, WIDTH bits: multiplier.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, 2*WIDTH bits: product, registered.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL accept a request when state is IDLE and start=1 (the accept edge). At that edge it SHALL:
- latch A, B and is_signed;
- clear the accumulator;
- load the counter with WIDTH;
- go to BUSY.
REQ-014 SHALL ignore start while in BUSY or DONE; latched operands SHALL NOT change mid-operation.
REQ-015 Operand changes on A, B and is_signed after the accept edge SHALL NOT affect the result.
REQ-016 Signed mode SHALL latch magnitudes |A| and |B| as WIDTH-bit unsigned values, plus neg = A[MSB] XOR B[MSB].
REQ-017 Unsigned mode SHALL latch A and B as-is, with neg = 0.
REQ-018 Each BUSY cycle SHALL perform one radix-2 shift-add step:
- if the multiplier LSB is 1, add the multiplicand to the upper WIDTH+1 accumulator bits;
- shift the {carry, accumulator} right by 1;
- shift the multiplier right by 1;
- decrement the counter.
REQ-019 The accumulator SHALL be 2*WIDTH bits with an explicit carry bit, so no carry out of an addition is lost.
REQ-020 BUSY SHALL last exactly WIDTH cycles, then go to DONE.
REQ-021 On entry to DONE, result SHALL be loaded with the accumulator, or its two's-complement negation when neg=1, modulo 2^(2*WIDTH).
REQ-022 done SHALL be 1 for exactly the one cycle the FSM is in DONE; DONE SHALL go unconditionally to IDLE.
REQ-023 Latency SHALL be WIDTH+1 rising edges from the accept edge to the edge that asserts done.
REQ-024 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-025 result SHALL hold its value from done until the next DONE entry; it SHALL NOT change during BUSY.
REQ-026 A new request MAY be accepted on the cycle after done, since the FSM is then in IDLE.
REQ-027 Boundary: A=0 or B=0 SHALL give result 0 with full latency; there is no early exit.
REQ-028 Boundary: signed -2^(WIDTH-1) operands SHALL have magnitude 2^(WIDTH-1) with no overflow.
REQ-029 Boundary: the signed product (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) SHALL be exact.
REQ-030 Boundary: unsigned max*max = 2^(2W) - 2^(W+1) + 1 SHALL be exact.
REQ-031 Start held high continuously SHALL produce back-to-back operations, each WIDTH+2 cycles apart.

Reset
REQ-032 With rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, result, counter, accumulator and latched operands to 0.
REQ-033 rst SHALL take priority over start.
REQ-034 rst asserted in BUSY or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-035 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-036 WIDTH=32, unsigned, A=0xFFFFFFFF, B=0xFFFFFFFF, start for 1 cycle -> done 33 edges after accept; result=0xFFFFFFFE00000001; busy high for 33 cycles.
REQ-037 WIDTH=32, signed, A=-3 (0xFFFFFFFD), B=7 -> result=0xFFFFFFFFFFFFFFEB (-21).
REQ-038 WIDTH=8, signed, A=0x80, B=0x80 -> result=0x4000; in unsigned mode, same operands -> result=0x4000; signed A=0x80, B=0x7F -> result=0xC080.
REQ-039 WIDTH=32: start pulsed again 5 cycles after accept with new operands -> ignored; first result unchanged.
REQ-040 WIDTH=32: A=6, B=7, then rst pulsed at BUSY cycle 10 -> busy=0, result=0, no done; next start with A=6, B=7 -> result=42 after 33 edges.
REQ-041 WIDTH=16: start held high with randomized operands for 1000 operations -> every result matches the reference model, with done spacing of 18 cycles.
